// File: rtl/audio_rx_pkg.sv
// Shared types and constants for the I2S ADC receive path.
package audio_rx_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } rx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous clock-like pin plus companion data pins into
// the system domain and produces a registered one-cycle strobe on its rising edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 edge_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 edge_rise,
  output logic [DATA_BITS-1:0] data_sync
);

  logic [SYNC_STAGES-1:0] edge_sr;
  logic                   edge_prev;
  logic [DATA_BITS-1:0]   data_sr [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_sr   <= '0;
      edge_prev <= 1'b0;
      edge_rise <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sr[i] <= '0;
    end else begin
      edge_sr   <= {edge_sr[SYNC_STAGES-2:0], edge_in};
      edge_prev <= edge_sr[SYNC_STAGES-1];
      edge_rise <= edge_sr[SYNC_STAGES-1] & ~edge_prev;
      data_sr[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
    end
  end

  assign data_sync = data_sr[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_adc_receiver.sv
// WM8731 I2S ADC deserialiser: oversamples BCLK/LRCK/DAT in the CLOCK_50 domain
// and presents each left/right pair on a valid/ready output.
module i2s_adc_receiver
  import audio_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  input  logic                  clear_overrun,
  output logic                  frame_error,
  output logic [1:0]            rx_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic       bclk_rise;
  logic [1:0] pin_sync;
  logic       lrck_s;
  logic       dat_s;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .DATA_BITS   (2)
  ) u_sync (
    .clk       (CLOCK_50),
    .rst       (RESET),
    .edge_in   (AUD_BCLK),
    .data_in   ({AUD_ADCLRCK, AUD_ADCDAT}),
    .edge_rise (bclk_rise),
    .data_sync (pin_sync)
  );

  assign lrck_s = pin_sync[1];
  assign dat_s  = pin_sync[0];

  rx_state_t             state;
  rx_state_t             state_next;
  logic                  lrck_prev;
  logic                  lrck_prev_valid;
  logic                  channel;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] left_hold;

  logic bit_strobe;
  logic boundary;
  logic fall_bnd;
  logic cnt_last;

  // A bit only counts once lrck_prev holds a real sample; the very first rise
  // after reset or enable just primes it.
  assign bit_strobe = enable & bclk_rise & lrck_prev_valid;
  assign boundary   = bit_strobe & (lrck_s != lrck_prev);
  assign fall_bnd   = boundary & ~lrck_s;
  assign cnt_last   = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign shift_next = {shift_reg[DATA_WIDTH-2:0], dat_s};

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = SYNC;
    end else begin
      case (state)
        SYNC:  if (fall_bnd) state_next = SHIFT;
        SHIFT: begin
          if (boundary)                    state_next = fall_bnd ? SHIFT : SYNC;
          else if (bit_strobe && cnt_last) state_next = PAD;
        end
        PAD:   if (boundary) state_next = SHIFT;
        default: state_next = SYNC;
      endcase
    end
  end

  logic start_left;
  logic start_right;
  logic shift_en;
  logic hold_left;
  logic load_pair;
  logic frame_err_set;

  always_comb begin
    start_left    = 1'b0;
    start_right   = 1'b0;
    shift_en      = 1'b0;
    hold_left     = 1'b0;
    load_pair     = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      SYNC: start_left = fall_bnd;
      SHIFT: begin
        if (boundary) begin
          // Short channel: drop it and let the same boundary resynchronise.
          frame_err_set = 1'b1;
          start_left    = fall_bnd;
        end else if (bit_strobe) begin
          shift_en  = 1'b1;
          hold_left = cnt_last & (channel == CH_LEFT);
          load_pair = cnt_last & (channel == CH_RIGHT);
        end
      end
      PAD: begin
        start_left  = fall_bnd;
        start_right = boundary & ~fall_bnd;
      end
      default: ;
    endcase
  end

  // Handshake: a pair transfers on any cycle with sample_valid & sample_ready;
  // valid drops after a transfer unless a new pair loads that same cycle, and a
  // load onto an untaken pair overwrites it and flags overrun.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      lrck_prev       <= 1'b0;
      lrck_prev_valid <= 1'b0;
      channel         <= CH_LEFT;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      left_hold       <= '0;
      left_data       <= '0;
      right_data      <= '0;
      sample_valid    <= 1'b0;
      overrun         <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      frame_error <= frame_err_set;

      if (!enable) begin
        lrck_prev_valid <= 1'b0;
      end else if (bclk_rise) begin
        lrck_prev       <= lrck_s;
        lrck_prev_valid <= 1'b1;
      end

      if (start_left || start_right) begin
        channel <= start_right ? CH_RIGHT : CH_LEFT;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift_reg <= shift_next;
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end

      if (hold_left) left_hold <= shift_next;

      if (load_pair) begin
        left_data    <= left_hold;
        right_data   <= shift_next;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (load_pair && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clear_overrun)                         overrun <= 1'b0;
    end
  end

  assign rx_state = state;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: drives I2S frames from a frame-level model and
// scores every transferred pair against a queue of the frames sent.
module tb_i2s_adc_receiver;

  localparam int DW = 24;
  localparam int SS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst;
  logic          bclk, lrck, dat;
  logic          enable;
  logic          sample_ready;
  logic          clear_overrun;
  logic [DW-1:0] left_data, right_data;
  logic          sample_valid, overrun, frame_error;
  logic [1:0]    rx_state;

  i2s_adc_receiver #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .CLOCK_50      (clk),
    .RESET         (rst),
    .AUD_BCLK      (bclk),
    .AUD_ADCLRCK   (lrck),
    .AUD_ADCDAT    (dat),
    .enable        (enable),
    .left_data     (left_data),
    .right_data    (right_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .frame_error   (frame_error),
    .rx_state      (rx_state)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2*DW-1:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          half_period = 8;
  int          ready_mode = 1;  // 0 never, 1 always, 2 random, 3 only on load cycle
  bit          mon_on = 1'b0;
  int unsigned lsb_cyc = 0;
  int          valid_pulses = 0;
  int          fe_pulses = 0;
  int          fe_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  // Codec changes LRCK/DAT on BCLK falling edges; the receiver samples on rises.
  task automatic drive_bit(input logic lr, input logic d, input bit is_lsb);
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    repeat (half_period) @(negedge clk);
    bclk = 1'b1;
    if (is_lsb) lsb_cyc = cyc;
    repeat (half_period) @(negedge clk);
  endtask

  // One I2S frame: each channel slot starts with the delay bit, then DW bits
  // MSB first, then random padding. en_off/en_on are global bit positions.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int lslot, input int rslot,
                            input int en_off, input int en_on, input bit push);
    if (push) exp_q.push_back({l, r});
    for (int ch = 0; ch < 2; ch++) begin
      int slot;
      slot = (ch == 0) ? lslot : rslot;
      for (int p = 0; p < slot; p++) begin
        int            g;
        logic          d;
        logic [DW-1:0] v;
        g = ch * lslot + p;
        if (g == en_off) enable = 1'b0;
        if (g == en_on)  enable = 1'b1;
        v = (ch == 0) ? l : r;
        d = (p >= 1 && p <= DW) ? v[DW-p] : 1'($urandom_range(0, 1));
        drive_bit(1'(ch), d, (ch == 1) && (p == DW));
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit valid_d;
    bit fe_d;
    logic [2*DW-1:0] e;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        case (ready_mode)
          0:       sample_ready = 1'b0;
          1:       sample_ready = 1'b1;
          2:       sample_ready = 1'($urandom_range(0, 1));
          default: sample_ready = (cyc == lsb_cyc + SS + 1);
        endcase
        if (sample_valid && sample_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 64'(sample_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("left_data", 64'(left_data), 64'(e[2*DW-1:DW]));
            check("right_data", 64'(right_data), 64'(e[DW-1:0]));
          end
        end
        if (sample_valid && !valid_d) begin
          valid_pulses++;
          check("pin_to_valid_latency", 64'(cyc - lsb_cyc), 64'(SS + 2));
        end
        valid_d = sample_valid;
        if (frame_error) begin
          fe_cycles++;
          if (!fe_d) fe_pulses++;
        end
        fe_d = frame_error;
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int vp0, fe0, fc0;
    logic [DW-1:0] l, r;
    rst = 1'b1; enable = 1'b0; sample_ready = 1'b1; clear_overrun = 1'b0;
    bclk = 1'b0; lrck = 1'b1; dat = 1'b0;

    // Reset with toggling codec pins
    repeat (3) begin
      @(negedge clk);
      bclk = 1'($urandom_range(0, 1));
      lrck = 1'($urandom_range(0, 1));
      dat  = 1'($urandom_range(0, 1));
    end
    check("rst_left", 64'(left_data), 64'd0);
    check("rst_right", 64'(right_data), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_frame_error", 64'(frame_error), 64'd0);
    check("rst_state", 64'(rx_state), 64'd0);
    bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
    rst = 1'b0; enable = 1'b1;
    mon_on = 1'b1; ready_mode = 1;
    repeat (3) drive_bit(1'b1, 1'b0, 1'b0);

    // Basic 64-bit frames, ready held high
    vp0 = valid_pulses;
    repeat (2) send_frame(24'hA5A5A5, 24'h123456, 32, 32, -1, -1, 1'b1);
    repeat (8) @(negedge clk);
    check("t2_valid_pulses", 64'(valid_pulses - vp0), 64'd2);
    check("t2_valid_idle", 64'(sample_valid), 64'd0);
    drain("t2_drain");

    // Overrun: two frames with ready low, newest pair kept
    ready_mode = 0;
    send_frame(24'h000001, 24'h000002, 32, 32, -1, -1, 1'b1);
    send_frame(24'h7FFFFF, 24'h800000, 32, 32, -1, -1, 1'b1);
    repeat (4) @(negedge clk);
    void'(exp_q.pop_front());
    check("t3_overrun_set", 64'(overrun), 64'd1);
    check("t3_valid_held", 64'(sample_valid), 64'd1);
    check("t3_left_newest", 64'(left_data), 64'h7FFFFF);
    check("t3_right_newest", 64'(right_data), 64'h800000);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    @(negedge clk);
    check("t3_overrun_cleared", 64'(overrun), 64'd0);
    ready_mode = 1;
    drain("t3_drain");

    // Short right channel (10 bits) then a good frame
    fe0 = fe_pulses; fc0 = fe_cycles; vp0 = valid_pulses;
    send_frame(24'h333333, 24'h444444, 32, 11, -1, -1, 1'b0);
    send_frame(24'h111111, 24'h222222, 32, 32, -1, -1, 1'b1);
    drain("t4_drain");
    check("t4_fe_pulses", 64'(fe_pulses - fe0), 64'd1);
    check("t4_fe_width", 64'(fe_cycles - fc0), 64'd1);
    check("t4_valid_pulses", 64'(valid_pulses - vp0), 64'd1);

    // Enable dropped mid-left, restored mid-right
    vp0 = valid_pulses;
    send_frame(24'h0F0F0F, 24'hF0F0F0, 32, 32, 10, 42, 1'b0);
    check("t5_no_output", 64'(valid_pulses - vp0), 64'd0);
    send_frame(24'h5A5A5A, 24'hC3C3C3, 32, 32, -1, -1, 1'b1);
    drain("t5_drain");
    check("t5_valid_pulses", 64'(valid_pulses - vp0), 64'd1);

    // Transfer on the exact load cycle
    ready_mode = 3;
    send_frame(24'hABCDEF, 24'h012345, 32, 32, -1, -1, 1'b1);
    send_frame(24'h654321, 24'hFEDCBA, 32, 32, -1, -1, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_queue_depth", 64'(exp_q.size()), 64'd1);
    check("t6_valid_kept", 64'(sample_valid), 64'd1);
    check("t6_left_new", 64'(left_data), 64'h654321);
    check("t6_right_new", 64'(right_data), 64'hFEDCBA);
    check("t6_no_overrun", 64'(overrun), 64'd0);
    ready_mode = 1;
    drain("t6_drain");

    // Randomized frames, BCLK rates and slot lengths, random ready
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      half_period = $urandom_range(2, 8);
      l = DW'($urandom);
      r = DW'($urandom);
      send_frame(l, r, $urandom_range(25, 32), $urandom_range(25, 32), -1, -1, 1'b1);
    end
    half_period = 8;
    repeat (2) drive_bit(1'b1, 1'b0, 1'b0);
    drain("rand_drain");
    check("final_overrun", 64'(overrun), 64'd0);
    check("final_fe_total", 64'(fe_pulses), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
